// File: rtl/pb_ram_arb_pkg.sv
// pb_ram_arb_pkg
// Shared types and constants for the PicoBlaze block-RAM arbiter.
//   owner_e        : lock ownership state (OWN_NONE / OWN_0 / OWN_1)
//   REQ0 / REQ1    : requester indices into the 2-bit request/grant vectors
//   DEF_*_W        : default widths for the arbiter parameters
package pb_ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_e;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pb_ram_arbiter_rr_pick2.sv
// rr_pick2
// Purely combinational 2-way round-robin picker.
//   req  [1:0] : raw requests, bit index = requester
//   last       : requester granted most recently (0 or 1)
//   mask [1:0] : requesters allowed to win this cycle (lock ownership)
//   gnt  [1:0] : one-hot grant (or zero when nobody eligible)
module rr_pick2 (
    input  logic       last,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] eff_s;

    // Eligible requests after ownership masking
    assign eff_s = req & mask;

    // On contention the requester that did not win last time goes next
    always_comb begin
        gnt = 2'b00;
        case (eff_s)
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/pb_ram_arbiter.sv
// pb_ram_arbiter
// Shares one single-port block RAM between two PicoBlaze cores.
// Grants are combinational from the registered round-robin pointer (and
// owner, when locking is built); read data returns one cycle later with a
// per-requester rvalid.
// Optional feature macro: PB_RAM_ARB_LOCK_EN (lock0/lock1 ownership for
// atomic read-modify-write). Without it the lock inputs are ignored.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   req*/we*/addr*/wdata*/lock*       requester access interfaces
//   gnt0/gnt1                         access performed this cycle
//   rvalid0/rvalid1, rdata            registered read return
//   ram_en/ram_we/ram_addr/ram_din    RAM control, muxed from the winner
//   ram_dout                          RAM read data
//   conflict_cnt                      saturating count of contested cycles
module pb_ram_arbiter
    import pb_ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              last_r;
    logic              rvalid0_r;
    logic              rvalid1_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        req_s;
    logic [1:0]        mask_s;
    logic [1:0]        pick_s;
    logic [1:0]        gnt_s;

    assign req_s = {req1, req0};

`ifdef PB_RAM_ARB_LOCK_EN
    owner_e owner_r;
    owner_e owner_nxt_s;

    // An owner excludes the other requester regardless of the pointer
    always_comb begin
        mask_s = 2'b11;
        case (owner_r)
            OWN_0:   mask_s = 2'b01;
            OWN_1:   mask_s = 2'b10;
            default: mask_s = 2'b11;
        endcase
    end

    // Ownership is taken by a locked grant and released by an unlocked
    // grant of the owner or by the owner dropping its request
    always_comb begin
        owner_nxt_s = owner_r;
        case (owner_r)
            OWN_0: begin
                if (!req0 || (gnt_s[REQ0] && !lock0)) begin
                    owner_nxt_s = OWN_NONE;
                end else begin
                    owner_nxt_s = OWN_0;
                end
            end
            OWN_1: begin
                if (!req1 || (gnt_s[REQ1] && !lock1)) begin
                    owner_nxt_s = OWN_NONE;
                end else begin
                    owner_nxt_s = OWN_1;
                end
            end
            OWN_NONE: begin
                if (gnt_s[REQ0] && lock0) begin
                    owner_nxt_s = OWN_0;
                end else if (gnt_s[REQ1] && lock1) begin
                    owner_nxt_s = OWN_1;
                end else begin
                    owner_nxt_s = OWN_NONE;
                end
            end
            default: owner_nxt_s = OWN_NONE;
        endcase
    end

    // Owner state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= owner_nxt_s;
        end
    end
`else
    logic unused_lock_s;

    assign unused_lock_s = lock0 ^ lock1;
    assign mask_s        = 2'b11;
`endif

    rr_pick2 u_pick (
        .last (last_r),
        .req  (req_s),
        .mask (mask_s),
        .gnt  (pick_s)
    );

    // Grants are forced off while reset is held so the RAM sees no access
    assign gnt_s = pick_s & {2{reset_n}};
    assign gnt0  = gnt_s[REQ0];
    assign gnt1  = gnt_s[REQ1];

    // RAM pin mux from the winner; idle pins are driven to zero
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt_s[REQ0]) begin
            ram_en   = 1'b1;
            ram_we   = we0;
            ram_addr = addr0;
            ram_din  = wdata0;
        end else if (gnt_s[REQ1]) begin
            ram_en   = 1'b1;
            ram_we   = we1;
            ram_addr = addr1;
            ram_din  = wdata1;
        end else begin
            ram_en   = 1'b0;
        end
    end

    // Round-robin pointer: remembers the most recent winner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_r <= 1'b1;
        end else if (gnt_s[REQ0]) begin
            last_r <= 1'b0;
        end else if (gnt_s[REQ1]) begin
            last_r <= 1'b1;
        end else begin
            last_r <= last_r;
        end
    end

    // Read-valid pipeline: one pulse per granted read, aligned with ram_dout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
        end else begin
            rvalid0_r <= gnt_s[REQ0] & ~we0;
            rvalid1_r <= gnt_s[REQ1] & ~we1;
        end
    end

    // Saturating count of cycles where both cores are requesting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (req0 && req1 && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign rvalid0      = rvalid0_r;
    assign rvalid1      = rvalid1_r;
    assign rdata        = ram_dout;
    assign conflict_cnt = cnt_r;

endmodule

// File: doc/pb_ram_arbiter.md
# pb_ram_arbiter

Two-requester arbiter that shares the single-port block RAM between the cipher PicoBlaze and the random-number PicoBlaze. It lets either core read and write the RAM without the other's port decode interfering. Each requester sees a req/gnt handshake with a registered read-valid return. The arbiter drives the RAM's enable, write-enable, address and data pins directly and returns the RAM's read data to the winner one cycle later.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- CNT_W, 16, width of the conflict counter

- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- lock0 / lock1  in  1  hold ownership after this access (used only with the lock feature)
- gnt0 / gnt1  out  1  access performed this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid on rdata (registered)
- rdata  out  DATA_W  shared read-data return, equal to ram_dout
- ram_en, ram_we  out  1  RAM enable / write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we = 0
- conflict_cnt  out  CNT_W  saturating count of cycles with both requests active

## Operation
- Each cycle the arbiter grants at most one requester; throughput is one access per cycle.
- Only one requester active: that requester is granted.
- Both requesters active: round-robin. Priority pointer `last` (reset value 1, so requester 0 wins first) selects the requester that was not granted most recently. `last` updates on every grant.
- Granted cycle:
  - ram_en = 1.
  - ram_we, ram_addr and ram_din are muxed from the winner.
  - No grant: ram_en = 0, ram_we = 0, ram_addr and ram_din = 0.
- Read return: a granted read sets rvalid of the winner high for exactly one cycle on the next edge; all other rvalid outputs stay 0.
- A write produces no rvalid.
- conflict_cnt increments in every cycle where req0 & req1; it saturates at all-ones.
- Reset (asynchronous, any time):
  - gnt0/1, rvalid0/1, ram_en and ram_we are 0 while reset_n is low.
  - conflict_cnt = 0, `last` = 1, owner = none.
  - A read granted in the cycle of reset assertion returns no rvalid.

## Timing
- Cycle N: req high and gnt high (combinational from the registered `last` and owner).
- The RAM samples the access at the end of cycle N.
- Cycle N+1: rvalid high and rdata valid (read latency is one cycle).
- Back-to-back reads from the same requester are allowed; rvalid stays high on consecutive cycles.
- A write in cycle N followed by a read of the same address in N+1 returns the new data in N+2.
- A requester must hold req, we, addr and wdata stable until it samples gnt = 1. It drops req, or presents the next access, in the following cycle.

## Configuration
- PB_RAM_ARB_LOCK_EN
  - Defined: a granted access with lockX = 1 sets owner = X. While owner = X, only X can be granted; the other requester waits regardless of `last`. Owner returns to none on X's first granted access with lockX = 0, or on any cycle with reqX = 0. This provides an atomic read-modify-write.
  - Not defined: lock0 and lock1 are ignored, the owner register is not built, and arbitration is pure round-robin. The ports remain so the interface is unchanged.

## Structure
- Package pb_ram_arb_pkg:
  - owner enum OWN_NONE / OWN_0 / OWN_1
  - requester index constants REQ0 = 0, REQ1 = 1
  - default widths
- Sub-module rr_pick2: 2-way round-robin picker. Inputs are the two requests, `last` and the owner mask; outputs are one-hot grants. It is purely combinational.
- The top module holds `last`, the owner, the rvalid pipeline registers, conflict_cnt and the RAM mux.

## Test plan
- Single requester: req0 read addr 0x10 (RAM holds 0x5A) -> gnt0 in the same cycle, rvalid0 = 1 with rdata = 0x5A the next cycle, rvalid1 = 0.
- Contention: req0 and req1 held for 4 reads after reset -> grants alternate 0, 1, 0, 1; conflict_cnt = 4 at the end.
- Write then read: req1 writes 0xC3 to 0x07, then req0 reads 0x07 -> rdata = 0xC3 with rvalid0.
- Lock (macro defined): req0 issues a locked read of 0x20 with req1 pending, then an unlocked write to 0x20 -> req1 is not granted until after the write. With the macro undefined, req1 is granted in the second cycle.
- Reset mid-read: reset_n asserted low in the grant cycle -> no rvalid; after release the first contested grant goes to requester 0 and conflict_cnt = 0.
- Saturation: CNT_W = 4 with 20 contested cycles -> conflict_cnt stays at 0xF.
